switch_input_ctrl: RTL and testbench
====================================

SWITCH_INPUT_CTRL -- requirements
Module: switch_input_ctrl

Interface
REQ-001 SHALL have parameter N, default cpuConfig::N (8): width of the captured data word, taken from SW[N-1:0]; N <= 8.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default cpuConfig::DEBOUNCE_CYCLES (16): consecutive stable cycles needed to accept a switch change; valid range 2..65535.
REQ-003 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port nRst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port SW, input, 10: raw board switches, asynchronous to clk. SW[8] = "data ready" handshake switch. SW[9] = clear.
REQ-006 SHALL have port switchesOut, output, N: captured data word presented to the cpu.
REQ-007 SHALL have port dataValid, output, 1: switchesOut holds a fresh word not yet consumed.
REQ-008 SHALL have port dataAck, input, 1: cpu consumed the word; synchronous to clk.
REQ-009 SHALL have port busy, output, 1: high in any state except IDLE.

Function
REQ-010 SHALL pass every used switch bit (SW[N-1:0], SW[8], SW[9]) through a 2-flop synchronizer before any other use.
REQ-011 SHALL, per debounced bit, flip the debounced value only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any intermediate match restarts the count at 0.
REQ-012 SHALL implement FSM states IDLE, VALID, WAIT_RELEASE.
REQ-013 In IDLE, on debounced SW[8]=1: SHALL latch the synchronized SW[N-1:0] into switchesOut, set dataValid=1 and move to VALID, all at the same edge.
REQ-014 In VALID: SHALL hold switchesOut and dataValid stable. On dataAck=1 sampled, SHALL clear dataValid and move to WAIT_RELEASE at that edge.
REQ-015 In WAIT_RELEASE: SHALL return to IDLE on debounced SW[8]=0. While SW[8] stays high, no new capture SHALL occur.
REQ-016 dataAck SHALL be ignored outside VALID.
REQ-017 A dataAck already high when VALID is entered SHALL still leave dataValid high for at least that one cycle; it takes effect on the next edge.
REQ-018 If SW[8] is released while in VALID, the FSM SHALL still wait for dataAck, then pass through WAIT_RELEASE for exactly one cycle.
REQ-019 Debounced SW[9]=1 SHALL force IDLE, dataValid=0 and switchesOut=0 from any state, taking priority over all other transitions.
REQ-020 SHALL not start a new capture while SW[9] is high.
REQ-021 Latency from the first clk edge sampling SW[8]=1 (stable) to dataValid=1: 3+DEBOUNCE_CYCLES edges.
REQ-022 The debounce counter SHALL saturate and never wrap.

Reset
REQ-023 While nRst=0: state=IDLE, switchesOut=0, dataValid=0, busy=0, all synchronizer flops=0, debounced values=0, counters=0.
REQ-024 Reset asserted mid-handshake SHALL discard the pending word. After release, a held-high SW[8] SHALL be captured again after the normal latency.

Configuration
REQ-025 Macro SWITCH_DEBOUNCE_EN: when defined, debouncing per REQ-011 is compiled in.
REQ-026 When SWITCH_DEBOUNCE_EN is undefined, the debounced value SHALL equal the synchronized value, DEBOUNCE_CYCLES SHALL be unused, and the latency SHALL be 3 edges.

Structure
REQ-027 cpuConfig package SHALL hold N, DEBOUNCE_CYCLES and the FSM state enum typedef (swState_t).
REQ-028 Sub-module debounce (synchronizer plus counter, 1 bit) SHALL be instantiated once per used switch bit. The top level SHALL hold only the FSM and the data register.

Verification (bench: N=8, DEBOUNCE_CYCLES=4, SWITCH_DEBOUNCE_EN defined unless stated)
REQ-029 SW=0x0A5, then SW[8] raised and held -> dataValid=1 exactly 7 edges later, switchesOut=0xA5, busy=1.
REQ-030 SW[8] bounce pattern 1,0,1,1,0, then stable 1 -> exactly one capture, dataValid rises 7 edges after the final stable 1.
REQ-031 dataAck pulsed 1 cycle in VALID with SW[8] held -> dataValid=0 next edge. SW[7:0] changed to 0x3C produces no capture until SW[8] is low for 4+ cycles and raised again, then switchesOut=0x3C.
REQ-032 SW[9]=1 held during VALID -> after 6 edges dataValid=0, switchesOut=0x00, busy=0. A later dataAck has no effect.
REQ-033 nRst pulsed low during VALID -> all outputs 0 immediately (asynchronous). With SW[8] still high after release, recapture occurs after 7 edges.
REQ-034 SWITCH_DEBOUNCE_EN undefined, SW=0x1FF -> dataValid=1 after 3 edges, switchesOut=0xFF.

Source files
------------

// File: rtl/switch_input_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpuConfig -- shared configuration for the switch input controller.
//
// Holds the default data width, the default debounce length and the
// handshake FSM state type used by switch_input_ctrl.
//
// Build option: SWITCH_DEBOUNCE_EN (see debounce) selects whether the
// per-bit debounce counter is compiled in.
// -----------------------------------------------------------------------------
package cpuConfig;

   localparam int N               = 8;
   localparam int DEBOUNCE_CYCLES = 16;

   // Width of the per-bit stability counter; covers DEBOUNCE_CYCLES up to 65535.
   localparam int DB_CNT_W        = 16;

   // Positions of the control switches on the SW bus.
   localparam int SW_READY_BIT    = 8;
   localparam int SW_CLEAR_BIT    = 9;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      VALID        = 2'd1,
      WAIT_RELEASE = 2'd2
   } swState_t;

endpackage : cpuConfig

// File: rtl/switch_input_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// debounce -- one switch bit: 2-flop synchronizer followed by an optional
// stability filter.
//
// Build option: SWITCH_DEBOUNCE_EN
//   defined   : the debounced value flips only after the synchronized value
//               has differed from it for DEBOUNCE_CYCLES consecutive cycles.
//   undefined : the debounced value is the synchronized value.
//
// Ports
//   clk       : system clock
//   nRst      : asynchronous active-low reset (clears every flop)
//   raw_i     : raw switch level, asynchronous to clk
//   sync_o    : synchronized level (second synchronizer flop)
//   db_o      : debounced level
//   db_next_o : level db_o will take after the next rising edge
// -----------------------------------------------------------------------------
module debounce #(
   parameter int DEBOUNCE_CYCLES = cpuConfig::DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic nRst,
   input  logic raw_i,
   output logic sync_o,
   output logic db_o,
   output logic db_next_o
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   always_comb begin
      sync1_d = raw_i;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign sync_o = sync2_q;

`ifdef SWITCH_DEBOUNCE_EN
   localparam int CW = cpuConfig::DB_CNT_W;
   // The flip happens on the edge that would complete the DEBOUNCE_CYCLES-th
   // differing cycle, so the count only ever reaches DEBOUNCE_CYCLES-1.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          db_q,  db_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      db_d  = db_q;
      cnt_d = '0;                         // any match restarts the count
      if (sync2_q != db_q) begin
         if (cnt_q >= CNT_LAST) begin
            db_d  = sync2_q;
            cnt_d = '0;
         end else if (cnt_q != {CW{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
         end else begin
            cnt_d = cnt_q;                // saturate, never wrap
         end
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         db_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         db_q  <= db_d;
         cnt_q <= cnt_d;
      end
   end

   assign db_o      = db_q;
   assign db_next_o = db_d;
`else
   assign db_o      = sync2_q;
   assign db_next_o = sync2_d;
`endif

endmodule : debounce

// File: rtl/switch_input_ctrl.sv
// -----------------------------------------------------------------------------
// switch_input_ctrl -- captures a data word from board switches under a
// switch-driven ready/acknowledge handshake with the cpu.
//
// Build option: SWITCH_DEBOUNCE_EN enables per-bit debouncing inside the
// debounce instances; without it the capture latency is 3 edges.
//
// Ports
//   clk         : system clock, rising edge
//   nRst        : asynchronous active-low reset
//   SW[9:0]     : raw switches; SW[N-1:0] data, SW[8] data ready, SW[9] clear
//   switchesOut : captured data word
//   dataValid   : switchesOut holds a word not yet acknowledged
//   dataAck     : cpu consumed the word (only honoured in VALID)
//   busy        : FSM is not in IDLE
// -----------------------------------------------------------------------------
module switch_input_ctrl #(
   parameter int N               = cpuConfig::N,
   parameter int DEBOUNCE_CYCLES = cpuConfig::DEBOUNCE_CYCLES
) (
   input  logic         clk,
   input  logic         nRst,
   input  logic [9:0]   SW,
   output logic [N-1:0] switchesOut,
   input  logic         dataAck,
   output logic         dataValid,
   output logic         busy
);

   logic [N-1:0] data_sync;
   logic [N-1:0] data_db;
   logic [N-1:0] data_db_next;
   logic         rdy_sync, rdy_db, rdy_db_next;
   logic         clr_sync, clr_db, clr_db_next;

   for (genvar gi = 0; gi < N; gi++) begin : g_data
      debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk       (clk),
         .nRst      (nRst),
         .raw_i     (SW[gi]),
         .sync_o    (data_sync[gi]),
         .db_o      (data_db[gi]),
         .db_next_o (data_db_next[gi])
      );
   end

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rdy (
      .clk       (clk),
      .nRst      (nRst),
      .raw_i     (SW[cpuConfig::SW_READY_BIT]),
      .sync_o    (rdy_sync),
      .db_o      (rdy_db),
      .db_next_o (rdy_db_next)
   );

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
      .clk       (clk),
      .nRst      (nRst),
      .raw_i     (SW[cpuConfig::SW_CLEAR_BIT]),
      .sync_o    (clr_sync),
      .db_o      (clr_db),
      .db_next_o (clr_db_next)
   );

   // Data is captured from the synchronized level; the debounced data levels
   // and the raw bus beyond N exist only for completeness.
   logic unused_sig;
   assign unused_sig = ^{data_db, data_db_next, rdy_sync, rdy_db_next, clr_sync, SW};

   cpuConfig::swState_t state_q, state_d;
   logic [N-1:0]        data_q,  data_d;
   logic                valid_q, valid_d;
   logic                busy_q,  busy_d;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = valid_q;
      // Clear acts on the edge where its debounced level rises, ahead of
      // every other transition.
      if (clr_db_next) begin
         state_d = cpuConfig::IDLE;
         data_d  = '0;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            cpuConfig::IDLE: begin
               if (rdy_db && !clr_db) begin
                  data_d  = data_sync;
                  valid_d = 1'b1;
                  state_d = cpuConfig::VALID;
               end
            end
            cpuConfig::VALID: begin
               if (dataAck) begin
                  valid_d = 1'b0;
                  state_d = cpuConfig::WAIT_RELEASE;
               end
            end
            cpuConfig::WAIT_RELEASE: begin
               if (!rdy_db) begin
                  state_d = cpuConfig::IDLE;
               end
            end
            default: begin
               state_d = cpuConfig::IDLE;
               data_d  = '0;
               valid_d = 1'b0;
            end
         endcase
      end
      busy_d = (state_d != cpuConfig::IDLE);
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= cpuConfig::IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign switchesOut = data_q;
   assign dataValid   = valid_q;
   assign busy        = busy_q;

endmodule : switch_input_ctrl

// File: tb/tb_switch_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_switch_input_ctrl -- directed self-checking bench for switch_input_ctrl
// (N=8, DEBOUNCE_CYCLES=4). Expected capture words go into a queue when
// SW[8] is raised and are popped when dataValid rises.
// Build option: SWITCH_DEBOUNCE_EN selects the debounced latencies.
// -----------------------------------------------------------------------------
module tb_switch_input_ctrl;

   localparam int N  = 8;
   localparam int DC = 4;
`ifdef SWITCH_DEBOUNCE_EN
   localparam int DB = DC;
`else
   localparam int DB = 0;
`endif
   localparam int LAT     = 3 + DB;   // SW[8] rise -> dataValid
   localparam int CLR_LAT = 2 + DB;   // SW[9] rise -> outputs cleared

   logic         clk = 1'b0;
   logic         nRst;
   logic [9:0]   SW;
   logic [N-1:0] switchesOut;
   logic         dataAck;
   logic         dataValid;
   logic         busy;

   int tests_run = 0;
   int tests_failed = 0;
   logic [7:0] exp_q[$];

   switch_input_ctrl #(.N(N), .DEBOUNCE_CYCLES(DC)) dut (
      .clk         (clk),
      .nRst        (nRst),
      .SW          (SW),
      .switchesOut (switchesOut),
      .dataAck     (dataAck),
      .dataValid   (dataValid),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for dataValid; returns the number of edges taken.
   task automatic wait_valid(output int n);
      n = 0;
      while (!dataValid && n < LAT + 20) begin
         tick();
         n++;
      end
   endtask

   // Pops the scoreboard and compares the presented word.
   task automatic check_capture(input string tag);
      logic [7:0] e;
      check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_data"}, 32'(switchesOut), 32'(e));
      end
   endtask

   task automatic capture(input logic [9:0] sw_val, input string tag);
      int n;
      SW = sw_val;
      exp_q.push_back(sw_val[7:0]);
      wait_valid(n);
      $display("[TB] %s: SW=0x%03h valid after %0d edges", tag, sw_val, n);
      check({tag, "_latency"}, 32'(n), 32'(LAT));
      check_capture(tag);
      check({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   initial begin
      int caps;
      nRst    = 1'b0;
      SW      = '0;
      dataAck = 1'b0;
      #1;
      check("reset_valid", 32'(dataValid), 32'd0);
      check("reset_data",  32'(switchesOut), 32'd0);
      check("reset_busy",  32'(busy), 32'd0);
      ticks(3);
      check("reset_held_valid", 32'(dataValid), 32'd0);
      nRst = 1'b1;
      ticks(2);

      // Basic capture of 0xA5.
      SW = 10'h0A5;
      ticks(3);
      capture(10'h1A5, "cap_a5");

      // Ack with SW[8] held, new data must not be captured until re-armed.
      dataAck = 1'b1;
      tick();
      dataAck = 1'b0;
      check("ack_valid", 32'(dataValid), 32'd0);
      check("ack_busy_wait", 32'(busy), 32'd1);
      SW = 10'h13C;
      caps = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (dataValid) caps++;
      end
      check("hold_no_capture", 32'(caps), 32'd0);
      check("hold_data_kept", 32'(switchesOut), 32'hA5);
      SW = 10'h03C;
      ticks(LAT);
      check("release_idle", 32'(busy), 32'd0);
      capture(10'h13C, "cap_3c");

      // SW[8] dropped in VALID: word held, ack, one WAIT_RELEASE cycle.
      SW = 10'h000;
      ticks(LAT + 2);
      check("drop_valid_held", 32'(dataValid), 32'd1);
      check("drop_data_held", 32'(switchesOut), 32'h3C);
      dataAck = 1'b1;
      tick();
      dataAck = 1'b0;
      check("drop_ack_valid", 32'(dataValid), 32'd0);
      check("drop_ack_busy", 32'(busy), 32'd1);
      tick();
      check("drop_one_wait_cycle", 32'(busy), 32'd0);

      // dataAck already high on entry to VALID: valid lasts one cycle.
      dataAck = 1'b1;
      capture(10'h15A, "cap_5a_ackhigh");
      tick();
      check("ackhigh_valid_clr", 32'(dataValid), 32'd0);
      dataAck = 1'b0;
      SW = 10'h05A;
      ticks(LAT + 1);
      check("ackhigh_release", 32'(busy), 32'd0);

`ifdef SWITCH_DEBOUNCE_EN
      // Bounce on SW[8] must be filtered out.
      caps = 0;
      foreach (SW[i]) begin end
      SW = 10'h1C3; tick(); if (dataValid) caps++;
      SW = 10'h0C3; tick(); if (dataValid) caps++;
      SW = 10'h1C3; tick(); if (dataValid) caps++;
      SW = 10'h1C3; tick(); if (dataValid) caps++;
      SW = 10'h0C3; tick(); if (dataValid) caps++;
      check("bounce_no_capture", 32'(caps), 32'd0);
`endif
      capture(10'h1C3, "cap_c3_after_bounce");

      // Clear while VALID.
      SW = 10'h3C3;
      ticks(CLR_LAT - 1);
      check("clr_not_yet", 32'(dataValid), 32'd1);
      tick();
      check("clr_valid", 32'(dataValid), 32'd0);
      check("clr_data", 32'(switchesOut), 32'd0);
      check("clr_busy", 32'(busy), 32'd0);
      dataAck = 1'b1;
      tick();
      dataAck = 1'b0;
      check("clr_ack_ignored_busy", 32'(busy), 32'd0);
      caps = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (dataValid || busy) caps++;
      end
      check("clr_no_capture", 32'(caps), 32'd0);
      SW = 10'h000;
      ticks(LAT + 2);

      // Asynchronous reset during VALID, then recapture with SW[8] held.
      capture(10'h1E7, "cap_e7");
      nRst = 1'b0;
      #1;
      check("arst_valid", 32'(dataValid), 32'd0);
      check("arst_data",  32'(switchesOut), 32'd0);
      check("arst_busy",  32'(busy), 32'd0);
      #1;
      nRst = 1'b1;
      capture(10'h1E7, "recap_e7");

      // All-ones word.
      dataAck = 1'b1;
      tick();
      dataAck = 1'b0;
      SW = 10'h0FF;
      ticks(LAT + 2);
      check("ff_pre_idle", 32'(busy), 32'd0);
      capture(10'h1FF, "cap_ff");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_switch_input_ctrl
